// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the unified 16-bit memory: setup, timed strobe, hold, done.
// Out-of-range requests finish without a strobe and flag addr_err alongside done.
module mem_access_unit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  state_t             state;
  logic               we;
  logic               err;
  logic [CNT_W-1:0]   cnt;
  logic               in_range;

  // Full-width unsigned compare so MEM_DEPTH up to 2**ADDR_W is handled.
  assign in_range = (32'(req_addr) < 32'(MEM_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      we        <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we        <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            busy      <= 1'b1;
            // Rejects pass through the strobe-free HOLD cycle to keep their one-edge latency.
            err       <= !in_range;
            state     <= in_range ? SETUP : HOLD;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= CNT_W'(WAIT_CYCLES - 1);
          mem_read  <= !we;
          mem_write <= we;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= HOLD;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!we) begin
              rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          state    <= DONE;
          done     <= 1'b1;
          addr_err <= err;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random bench for mem_access_unit with a behavioural 256-word memory.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [15:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];
  logic [15:0] sh_mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] exp_rdata;

  int n_tests;
  int n_fail;

  mem_access_unit dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .busy     (busy),
    .done     (done),
    .addr_err (addr_err),
    .rdata    (rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: synchronous write, asynchronous read; bench preload port when the DUT is not writing.
  always @(posedge clock) begin
    if (mem_write && (mem_addr < 16'd256)) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    sh_mem[a] = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  // One request from an idle DUT; checks latency, strobes, address stability and rdata.
  task automatic run_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int  done_k, first_s, last_s, n_rd, n_wr;
    bit  both, moved, err_seen, inr;
    inr = (addr < 16'd256);
    done_k = -1; first_s = -1; last_s = -1; n_rd = 0; n_wr = 0;
    both = 1'b0; moved = 1'b0; err_seen = 1'b0;
    req_we = we; req_addr = addr; req_wdata = wdata; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (mem_read || mem_write) begin
        if (first_s < 0) first_s = k;
        last_s = k;
      end
      if (mem_read && mem_write) both = 1'b1;
      if (busy && (mem_addr !== addr)) moved = 1'b1;
      if (done) begin
        done_k = k;
        err_seen = addr_err;
        break;
      end
      @(posedge clock); #1;
    end
    if (inr && we) sh_mem[addr[7:0]] = wdata;
    if (inr && !we) exp_rdata = sh_mem[addr[7:0]];
    check("done_latency", 32'(done_k), inr ? 32'd4 : 32'd1);
    check("addr_err", 32'(err_seen), 32'(!inr));
    check("read_strobes", 32'(n_rd), (inr && !we) ? 32'd2 : 32'd0);
    check("write_strobes", 32'(n_wr), (inr && we) ? 32'd2 : 32'd0);
    if (inr) begin
      check("strobe_first", 32'(first_s), 32'd1);
      check("strobe_last", 32'(last_s), 32'd2);
    end
    check("strobe_exclusive", 32'(both), 32'd0);
    check("addr_stable", 32'(moved), 32'd0);
    check("rdata", 32'(rdata), 32'(exp_rdata));
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone, nwr;
    n_tests = 0; n_fail = 0;
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; exp_rdata = '0;

    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      pre_data = 16'(i * 7 + 3);
      sh_mem[i] = 16'(i * 7 + 3);
      pre_we = 1'b1;
      @(posedge clock); #1;
    end
    pre_we = 1'b0;

    // Reset with req asserted
    req = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hFFFF;
    repeat (2) begin
      @(posedge clock); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    end
    reset = 1'b0; req = 1'b0;
    @(posedge clock); #1;

    // Store then load back
    run_req(1'b1, 16'h0010, 16'hBEEF);
    check("mem_store", 32'(mem[8'h10]), 32'h0000BEEF);
    run_req(1'b0, 16'h0010, 16'h0000);
    check("load_back", 32'(rdata), 32'h0000BEEF);

    // Address boundary
    preload(8'hFF, 16'h1234);
    run_req(1'b0, 16'h00FF, 16'h0000);
    check("load_top", 32'(rdata), 32'h00001234);
    run_req(1'b0, 16'h0100, 16'h0000);
    check("reject_keeps_rdata", 32'(rdata), 32'h00001234);
    run_req(1'b1, 16'hFFFF, 16'h5A5A);

    // Request during ACCESS is ignored
    preload(8'h05, 16'h5555);
    preload(8'h06, 16'h6666);
    req_we = 1'b0; req_addr = 16'h0005; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    req = 1'b1; req_we = 1'b1; req_addr = 16'h0006; req_wdata = 16'hDEAD;
    @(posedge clock); #1;
    req = 1'b0;
    ndone = 0; nwr = 0;
    repeat (20) begin
      if (done) ndone++;
      if (mem_write) nwr++;
      @(posedge clock); #1;
    end
    check("busy_one_done", 32'(ndone), 32'd1);
    check("busy_no_write", 32'(nwr), 32'd0);
    check("busy_mem6", 32'(mem[8'h06]), 32'h00006666);
    check("busy_rdata", 32'(rdata), 32'h00005555);

    // Reset in the middle of a load
    preload(8'h20, 16'hAAAA);
    req_we = 1'b0; req_addr = 16'h0020; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    check("midrst_in_access", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    exp_rdata = '0;
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      @(posedge clock); #1;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    // Random traffic, including out-of-range addresses
    for (int i = 0; i < 50; i++) begin
      run_req(1'($urandom), 16'($urandom_range(16'h011F, 0)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
